// File: rtl/seq_datapath_pkg.sv
// Shared types and instruction decode helpers for the bus-based sequential datapath.
package seq_datapath_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_MOV  = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_T1   = 2'b01,
    S_T2   = 2'b10,
    S_T3   = 2'b11
  } state_e;

  localparam int unsigned MAX_IDX_W   = 4;
  localparam int unsigned MAX_INSTR_W = 2 + 2 * MAX_IDX_W;

  typedef struct packed {
    op_e                  op;
    logic [MAX_IDX_W-1:0] rx;
    logic [MAX_IDX_W-1:0] ry;
  } instr_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Fields are packed {op, rx, ry} with rx/ry each idx_w bits wide.
  function automatic instr_t decode_instr(input logic [MAX_INSTR_W-1:0] raw,
                                          input int unsigned idx_w);
    instr_t               d;
    logic [MAX_IDX_W-1:0] mask;
    mask = MAX_IDX_W'((1 << idx_w) - 1);
    d.ry = raw[MAX_IDX_W-1:0] & mask;
    d.rx = MAX_IDX_W'(raw >> idx_w) & mask;
    d.op = op_e'(raw[2*idx_w +: 2]);
    return d;
  endfunction

endpackage

// File: rtl/seq_datapath_regfile.sv
// General register file: one write port, bus and debug read ports; out-of-range
// indices read as zero and never write.
module seq_datapath_regfile
  import seq_datapath_pkg::*;
#(
  parameter  int unsigned DATA_W   = 8,
  parameter  int unsigned NUM_REGS = 4,
  localparam int unsigned IDX_W    = idx_width(NUM_REGS)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  input  logic [IDX_W-1:0]  i_dbg_sel,
  output logic [DATA_W-1:0] o_dbg_data
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        if (IDX_W'(i) == i_waddr) r_regs[i] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata    = '0;
    o_dbg_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (IDX_W'(i) == i_raddr)   o_rdata    = r_regs[i];
      if (IDX_W'(i) == i_dbg_sel) o_dbg_data = r_regs[i];
    end
  end

endmodule

// File: rtl/seq_datapath_proc.sv
// Sequential bus-based processor: control FSM, accumulator A, result G and an
// add/sub ALU sharing one internal bus with the register file.
module seq_datapath_proc
  import seq_datapath_pkg::*;
#(
  parameter  int unsigned DATA_W   = 8,
  parameter  int unsigned NUM_REGS = 4,
  localparam int unsigned IDX_W    = idx_width(NUM_REGS),
  localparam int unsigned INSTR_W  = 2 + 2 * IDX_W
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               run,
  input  logic [INSTR_W-1:0] instr,
  input  logic [DATA_W-1:0]  data,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  bus_output,
  input  logic [IDX_W-1:0]   rd_sel,
  output logic [DATA_W-1:0]  rd_data
);

  state_e             r_state, w_next;
  logic [INSTR_W-1:0] r_ir;
  logic [DATA_W-1:0]  r_dr, r_a, r_g;

  instr_t             w_dec;
  op_e                w_op;
  logic [IDX_W-1:0]   w_rx, w_ry, w_raddr;
  logic               w_arith;
  logic [DATA_W-1:0]  w_bus, w_rdata;
  logic               w_we, w_a_ld, w_g_ld, w_done;

  assign w_dec   = decode_instr(MAX_INSTR_W'(r_ir), IDX_W);
  assign w_op    = w_dec.op;
  assign w_rx    = w_dec.rx[IDX_W-1:0];
  assign w_ry    = w_dec.ry[IDX_W-1:0];
  assign w_arith = (w_op == OP_ADD) || (w_op == OP_SUB);
  // The single bus read port serves rx in arithmetic T1, ry everywhere else.
  assign w_raddr = (r_state == S_T1 && w_arith) ? w_rx : w_ry;

  seq_datapath_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk        (clk),
    .resetn     (resetn),
    .i_we       (w_we),
    .i_waddr    (w_rx),
    .i_wdata    (w_bus),
    .i_raddr    (w_raddr),
    .o_rdata    (w_rdata),
    .i_dbg_sel  (rd_sel),
    .o_dbg_data (rd_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (run) w_next = S_T1;
      S_T1:    w_next = w_arith ? S_T2 : S_IDLE;
      S_T2:    w_next = S_T3;
      S_T3:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_bus  = '0;
    w_we   = 1'b0;
    w_a_ld = 1'b0;
    w_g_ld = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_T1: begin
        if (w_arith) begin
          w_bus  = w_rdata;
          w_a_ld = 1'b1;
        end else begin
          w_bus  = (w_op == OP_LOAD) ? r_dr : w_rdata;
          w_we   = 1'b1;
          w_done = 1'b1;
        end
      end
      S_T2: begin
        w_bus  = w_rdata;
        w_g_ld = 1'b1;
      end
      S_T3: begin
        w_bus  = r_g;
        w_we   = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ir <= '0;
      r_dr <= '0;
      r_a  <= '0;
      r_g  <= '0;
    end else begin
      if (r_state == S_IDLE && run) begin
        r_ir <= instr;
        r_dr <= data;
      end
      if (w_a_ld) r_a <= w_bus;
      if (w_g_ld) r_g <= (w_op == OP_SUB) ? r_a - w_bus : r_a + w_bus;
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = w_done;
  assign bus_output = w_bus;

endmodule

// File: tb/tb_seq_datapath_proc.sv
// Directed bench for seq_datapath_proc: a 4-register instance and a 3-register
// instance for the out-of-range index path.
module tb_seq_datapath_proc;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic       run = 1'b0;
  logic [5:0] instr = '0;
  logic [7:0] data = '0;
  logic       busy, done;
  logic [7:0] bus_output;
  logic [1:0] rd_sel = '0;
  logic [7:0] rd_data;

  logic       run3 = 1'b0;
  logic [5:0] instr3 = '0;
  logic [7:0] data3 = '0;
  logic       busy3, done3;
  logic [7:0] bus3;
  logic [1:0] rd_sel3 = '0;
  logic [7:0] rd_data3;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] LD = 2'd0, MV = 2'd1, AD = 2'd2, SB = 2'd3;

  seq_datapath_proc #(.DATA_W(8), .NUM_REGS(4)) dut (
    .clk(clk), .resetn(resetn), .run(run), .instr(instr), .data(data),
    .busy(busy), .done(done), .bus_output(bus_output),
    .rd_sel(rd_sel), .rd_data(rd_data)
  );

  seq_datapath_proc #(.DATA_W(8), .NUM_REGS(3)) dut3 (
    .clk(clk), .resetn(resetn), .run(run3), .instr(instr3), .data(data3),
    .busy(busy3), .done(done3), .bus_output(bus3),
    .rd_sel(rd_sel3), .rd_data(rd_data3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns in T1 of the issued instruction.
  task automatic issue(input logic [1:0] op, input logic [1:0] rx,
                       input logic [1:0] ry, input logic [7:0] d);
    run = 1'b1; instr = {op, rx, ry}; data = d;
    step();
    run = 1'b0;
  endtask

  // Runs an instruction to completion and returns in IDLE.
  task automatic exec(input logic [1:0] op, input logic [1:0] rx,
                      input logic [1:0] ry, input logic [7:0] d);
    issue(op, rx, ry, d);
    if (op[1]) begin step(); step(); end
    step();
  endtask

  task automatic peek(input logic [1:0] idx, output logic [7:0] v);
    rd_sel = idx; #1; v = rd_data;
  endtask

  task automatic peek3(input logic [1:0] idx, output logic [7:0] v);
    rd_sel3 = idx; #1; v = rd_data3;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    resetn = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (bus_output !== 8'h00) begin errors++; $display("FAIL rst_bus got %h want 00", bus_output); end
    for (int i = 0; i < 4; i++) begin
      peek(2'(i), v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL rst_reg%0d got %h want 00", i, v); end
    end
    resetn = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_load();
    logic [7:0] v;
    issue(LD, 2'd1, 2'd0, 8'h02);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL load_done got %b want 1", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy got %b want 1", busy); end
    checks++; if (bus_output !== 8'h02) begin errors++; $display("FAIL load_bus got %h want 02", bus_output); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL load_done_clr got %b want 0", done); end
    peek(2'd1, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL load_r1 got %h want 02", v); end
  endtask

  task automatic test_add_wrap();
    logic [7:0] v;
    exec(LD, 2'd0, 2'd0, 8'hFF);
    exec(LD, 2'd1, 2'd0, 8'h02);
    issue(AD, 2'd0, 2'd1, 8'h00);
    checks++; if (done !== 1'b0 || bus_output !== 8'hFF) begin errors++; $display("FAIL add_t1 got done=%b bus=%h want 0/ff", done, bus_output); end
    step();
    checks++; if (done !== 1'b0 || bus_output !== 8'h02) begin errors++; $display("FAIL add_t2 got done=%b bus=%h want 0/02", done, bus_output); end
    step();
    checks++; if (done !== 1'b1 || bus_output !== 8'h01) begin errors++; $display("FAIL add_t3 got done=%b bus=%h want 1/01", done, bus_output); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_end_busy got %b want 0", busy); end
    peek(2'd0, v);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL add_r0 got %h want 01", v); end
    peek(2'd1, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL add_r1 got %h want 02", v); end
  endtask

  task automatic test_sub();
    logic [7:0] v;
    exec(SB, 2'd0, 2'd0, 8'h00);
    peek(2'd0, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL sub_self got %h want 00", v); end
    exec(LD, 2'd2, 2'd0, 8'h10);
    exec(LD, 2'd3, 2'd0, 8'h11);
    issue(SB, 2'd2, 2'd3, 8'h00);
    checks++; if (bus_output !== 8'h10) begin errors++; $display("FAIL sub_t1_bus got %h want 10", bus_output); end
    step();
    checks++; if (bus_output !== 8'h11) begin errors++; $display("FAIL sub_t2_bus got %h want 11", bus_output); end
    step();
    checks++; if (bus_output !== 8'hFF || done !== 1'b1) begin errors++; $display("FAIL sub_t3 got bus=%h done=%b want ff/1", bus_output, done); end
    step();
    peek(2'd2, v);
    checks++; if (v !== 8'hFF) begin errors++; $display("FAIL sub_r2 got %h want ff", v); end
    peek(2'd3, v);
    checks++; if (v !== 8'h11) begin errors++; $display("FAIL sub_r3 got %h want 11", v); end
  endtask

  task automatic test_mov_busy();
    logic [7:0] v;
    issue(MV, 2'd3, 2'd1, 8'h00);
    checks++; if (done !== 1'b1 || bus_output !== 8'h02) begin errors++; $display("FAIL mov_t1 got done=%b bus=%h want 1/02", done, bus_output); end
    step();
    peek(2'd3, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL mov_r3 got %h want 02", v); end
    issue(AD, 2'd0, 2'd1, 8'h00);
    run = 1'b1; instr = {LD, 2'd3, 2'd0}; data = 8'hAA;
    step();
    run = 1'b0;
    checks++; if (bus_output !== 8'h02 || busy !== 1'b1) begin errors++; $display("FAIL ign_t2 got bus=%h busy=%b want 02/1", bus_output, busy); end
    step();
    checks++; if (done !== 1'b1 || bus_output !== 8'h02) begin errors++; $display("FAIL ign_t3 got done=%b bus=%h want 1/02", done, bus_output); end
    step();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_queued got busy=%b want 0", busy); end
    peek(2'd3, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL ign_r3 got %h want 02", v); end
    peek(2'd0, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL ign_r0 got %h want 02", v); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    run = 1'b1; instr = {LD, 2'd0, 2'd0}; data = 8'h33;
    step();
    checks++; if (done !== 1'b1 || bus_output !== 8'h33) begin errors++; $display("FAIL b2b_first got done=%b bus=%h want 1/33", done, bus_output); end
    instr = {LD, 2'd1, 2'd0}; data = 8'h44;
    step();
    checks++; if (busy !== 1'b0 || bus_output !== 8'h00) begin errors++; $display("FAIL b2b_idle got busy=%b bus=%h want 0/00", busy, bus_output); end
    step();
    run = 1'b0;
    checks++; if (busy !== 1'b1 || bus_output !== 8'h44) begin errors++; $display("FAIL b2b_second got busy=%b bus=%h want 1/44", busy, bus_output); end
    step();
    peek(2'd0, v);
    checks++; if (v !== 8'h33) begin errors++; $display("FAIL b2b_r0 got %h want 33", v); end
    peek(2'd1, v);
    checks++; if (v !== 8'h44) begin errors++; $display("FAIL b2b_r1 got %h want 44", v); end
  endtask

  task automatic test_npot();
    logic [7:0] v;
    logic [7:0] want [3];
    want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      run3 = 1'b1; instr3 = {LD, 2'(i), 2'd0}; data3 = want[i];
      step();
      run3 = 1'b0;
      step();
    end
    run3 = 1'b1; instr3 = {LD, 2'd3, 2'd0}; data3 = 8'h55;
    step();
    run3 = 1'b0;
    checks++; if (done3 !== 1'b1 || bus3 !== 8'h55) begin errors++; $display("FAIL npot_t1 got done=%b bus=%h want 1/55", done3, bus3); end
    step();
    checks++; if (busy3 !== 1'b0 || done3 !== 1'b0) begin errors++; $display("FAIL npot_end got busy=%b done=%b want 0/0", busy3, done3); end
    peek3(2'd3, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL npot_r3 got %h want 00", v); end
    for (int i = 0; i < 3; i++) begin
      peek3(2'(i), v);
      checks++; if (v !== want[i]) begin errors++; $display("FAIL npot_r%0d got %h want %h", i, v, want[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    logic       saw_done;
    issue(AD, 2'd0, 2'd1, 8'h00);
    step();
    checks++; if (bus_output !== 8'h44) begin errors++; $display("FAIL mid_t2_bus got %h want 44", bus_output); end
    resetn = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || bus_output !== 8'h00) begin errors++; $display("FAIL mid_rst got busy=%b done=%b bus=%h want 0/0/00", busy, done, bus_output); end
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done !== 1'b0) saw_done = 1'b1;
    end
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done !== 1'b0) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL mid_done_pulse got %b want 0", saw_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
    for (int i = 0; i < 4; i++) begin
      peek(2'(i), v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL mid_reg%0d got %h want 00", i, v); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_add_wrap();
    test_sub();
    test_mov_busy();
    test_back_to_back();
    test_npot();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_datapath_proc.md
# seq_datapath_proc

Parametrised bus-based processor: a register file of `NUM_REGS` × `DATA_W` registers, an accumulator A, a result register G and an adder/subtractor sharing one internal bus, sequenced by an on-block control FSM. It supersedes the hand-driven datapath whose `reg_sig`/`A_in`/`G_in`/`G_out` strobes were toggled externally. The block accepts one instruction per `run` handshake and executes it in 1 or 3 cycles. It sits between the instruction source (switches or test harness) and the display/bus observer.

## Interface
- `DATA_W`, 8: register, bus and ALU width (≥2).
- `NUM_REGS`, 4: number of general registers (2..16); `IDX_W = max(1, clog2(NUM_REGS))`.
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `run`  in  1  start request, sampled only in IDLE.
- `instr`  in  2+2·IDX_W  `{op[1:0], rx[IDX_W-1:0], ry[IDX_W-1:0]}`, sampled with `run`.
- `data`  in  DATA_W  immediate operand for LOAD, sampled with `run`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  high for exactly one cycle, the final cycle of an instruction.
- `bus_output`  out  DATA_W  current internal bus value.
- `rd_sel`  in  IDX_W  debug read select (combinational).
- `rd_data`  out  DATA_W  contents of R[`rd_sel`]; 0 if out of range.

## Operation
- Opcodes: 00 LOAD R[rx]←data; 01 MOV R[rx]←R[ry]; 10 ADD R[rx]←R[rx]+R[ry]; 11 SUB R[rx]←R[rx]−R[ry].
- States: IDLE, T1, T2, T3.
- IDLE: when `run`=1 at an edge, latch `instr` into IR and `data` into DR, then go to T1. Otherwise stay in IDLE.
- T1, LOAD: bus=DR, write R[rx], `done`=1, go to IDLE.
- T1, MOV: bus=R[ry], write R[rx], `done`=1, go to IDLE.
- T1, ADD/SUB: bus=R[rx], A←bus, go to T2.
- T2: bus=R[ry], G←A±bus, go to T3.
- T3: bus=G, R[rx]←G, `done`=1, go to IDLE.
- Arithmetic is modulo 2^DATA_W; carry and borrow are discarded.
- rx==ry is legal: ADD doubles the register, SUB yields 0, MOV is a no-op write.
- An out-of-range index (NUM_REGS not a power of two) reads as 0, and its write is suppressed. The instruction still completes with normal timing.
- `run` while `busy` is ignored and not queued. `run` held high re-issues a new instruction on the first IDLE edge.
- The bus has exactly one driver per state. In IDLE it is 0.

## Timing
- Reset (async assert, sync-safe deassert) clears all of the following: R[*], A, G, IR and DR to 0; state to IDLE; `busy`=0, `done`=0, `bus_output`=0.
- Reset mid-instruction aborts it. No partial write survives.
- LOAD/MOV: `run` sampled at edge k. T1 occupies cycle k→k+1. The write is visible at edge k+1, and `done` is high in that cycle.
- ADD/SUB: T1, T2, T3 occupy 3 cycles. The result is visible after the third edge following the `run` sample, and `done` is high during T3.
- Back-to-back: the next `run` is accepted at the edge that returns to IDLE + 1 cycle. IDLE lasts at least one cycle.
- `done` and `busy` are decoded from registered state. `bus_output` and `rd_data` are combinational from state and registers.

## Structure
- Package `seq_datapath_pkg`:
  - opcode enum (LOAD, MOV, ADD, SUB);
  - state enum (IDLE, T1, T2, T3);
  - instruction field-slicing helper.
- Sub-module `seq_datapath_regfile`, parametrised by DATA_W and NUM_REGS:
  - one write port;
  - two combinational read ports (bus source and debug);
  - async active-low clear.
- FSM, A, G, ALU and bus mux live in the top.

## Test plan
- LOAD path (DATA_W=8, NUM_REGS=4): reset, then LOAD R1←0x02. Require `done` 1 cycle after `run`, `bus_output`=0x02 in T1, `rd_data`(1)=0x02.
- ADD with wrap: LOAD R0←0xFF, LOAD R1←0x02, ADD R0,R1. Require `done` in the 3rd cycle, R0=0x01, R1 unchanged.
- SUB sequence: SUB R0,R0 → R0=0x00. Then LOAD R2←0x10, LOAD R3←0x11, SUB R2,R3 → R2=0xFF. Require the bus sequence 0x10, 0x11, 0xFF during T1–T3.
- MOV then busy-ignore: MOV R3←R1. Pulse `run` with LOAD R3←0xAA during T1 of an ADD. Require the LOAD to be ignored and R3 to hold the MOV value.
- Reset mid-op: assert `resetn`=0 during T2 of ADD. Require all registers = 0, `busy`=0, `done` never pulses.
- Non-power-of-two: NUM_REGS=3, LOAD R3←0x55. Require `done` after 1 cycle, `rd_data`(3)=0, R0–R2 unchanged.
